// File: rtl/miner_pkg.sv
// miner_pkg: shared types, constants and block helpers for the mining job controller
package miner_pkg;
    typedef enum logic [1:0] {IDLE, MID_REQ, MID_WAIT, RUN} state_e;
    typedef logic [255:0] midstate_t;
    typedef logic [511:0] block_t;
    localparam int NONCE_WORD_IDX = 3;
    localparam logic [31:0] PAD_WORD = 32'h8000_0000;
    localparam logic [31:0] LEN_WORD = 32'h0000_0280;
    function automatic block_t set_word(input block_t b, input int idx, input logic [31:0] w);
        block_t r;
        r = b;
        r[511-32*idx -: 32] = w;
        return r;
    endfunction
endpackage

// File: rtl/miner_blockgen.sv
// miner_blockgen: forwards block 1 and builds the padded second header block with an empty nonce slot
module miner_blockgen
    import miner_pkg::*;
(
    input  block_t      block1,
    input  logic [95:0] tail,
    output block_t      mid_block,
    output block_t      block2
);
    assign mid_block = block1;
    assign block2 = {tail, 32'h0, PAD_WORD, 320'h0, LEN_WORD};
endmodule

// File: rtl/miner_job_ctrl.sv
// miner_job_ctrl: sequences midstate request and per-nonce job issue for one SHA-256d lane
module miner_job_ctrl
    import miner_pkg::*;
#(
    parameter int unsigned STEP = 1
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          work_valid,
    output logic          work_ready,
    input  logic [511:0]  work_block1,
    input  logic [95:0]   work_tail,
    input  logic [31:0]   work_nonce_start,
    input  logic [31:0]   work_nonce_end,
    input  logic          abort,
    output logic          mid_req_valid,
    input  logic          mid_req_ready,
    output logic [511:0]  mid_block_o,
    input  logic          mid_done_valid,
    input  logic [255:0]  mid_state,
    output logic          job_valid,
    input  logic          job_ready,
    output logic [255:0]  job_midstate,
    output logic [511:0]  job_block2,
    output logic [31:0]   job_nonce,
    output logic          busy,
    output logic          exhausted,
    output logic [31:0]   jobs_issued
);
    state_e      state_q, state_d;
    block_t      blk1_q, blk1_d;
    logic [95:0] tail_q, tail_d;
    logic [31:0] start_q, start_d, end_q, end_d, nonce_q, nonce_d, jobs_q, jobs_d;
    midstate_t   mid_q, mid_d;
    logic        exh_q, exh_d, loaded_q, loaded_d;
    logic        work_ready_q, mid_req_valid_q, job_valid_q, busy_q;
    logic        hs, last;
    block_t      gen_mid_block, gen_block2;

    miner_blockgen u_blockgen (
        .block1    (blk1_q),
        .tail      (tail_q),
        .mid_block (gen_mid_block),
        .block2    (gen_block2)
    );

    always_comb begin
        state_d  = state_q;
        blk1_d   = blk1_q;
        tail_d   = tail_q;
        start_d  = start_q;
        end_d    = end_q;
        nonce_d  = nonce_q;
        mid_d    = mid_q;
        exh_d    = 1'b0;
        loaded_d = loaded_q;
        hs       = state_q == RUN && job_ready;
        // 33-bit compare so a range ending at FFFF_FFFF terminates instead of wrapping
        last     = ({1'b0, nonce_q} + 33'(STEP)) > {1'b0, end_q};
        jobs_d   = hs ? ((&jobs_q) ? jobs_q : jobs_q + 32'd1) : jobs_q;
        case (state_q)
            IDLE: if (work_valid) begin
                blk1_d   = work_block1;
                tail_d   = work_tail;
                start_d  = work_nonce_start;
                end_d    = work_nonce_end;
                jobs_d   = '0;
                loaded_d = 1'b1;
                state_d  = MID_REQ;
            end
            MID_REQ: state_d = mid_req_ready ? MID_WAIT : MID_REQ;
            MID_WAIT: if (mid_done_valid) begin
                mid_d   = mid_state;
                nonce_d = start_q;
                state_d = RUN;
            end
            RUN: if (job_ready) begin
                state_d = last ? IDLE : RUN;
                exh_d   = last;
                nonce_d = last ? nonce_q : nonce_q + 32'(STEP);
            end
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            blk1_q          <= '0;
            tail_q          <= '0;
            start_q         <= '0;
            end_q           <= '0;
            nonce_q         <= '0;
            jobs_q          <= '0;
            mid_q           <= '0;
            exh_q           <= 1'b0;
            loaded_q        <= 1'b0;
            work_ready_q    <= 1'b1;
            mid_req_valid_q <= 1'b0;
            job_valid_q     <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            blk1_q          <= blk1_d;
            tail_q          <= tail_d;
            start_q         <= start_d;
            end_q           <= end_d;
            nonce_q         <= nonce_d;
            jobs_q          <= jobs_d;
            mid_q           <= mid_d;
            exh_q           <= exh_d;
            loaded_q        <= loaded_d;
            work_ready_q    <= state_d == IDLE;
            mid_req_valid_q <= state_d == MID_REQ;
            job_valid_q     <= state_d == RUN;
            busy_q          <= state_d != IDLE;
        end
    end

    assign work_ready    = work_ready_q;
    assign mid_req_valid = mid_req_valid_q;
    assign job_valid     = job_valid_q;
    assign busy          = busy_q;
    assign exhausted     = exh_q;
    assign jobs_issued   = jobs_q;
    assign job_nonce     = nonce_q;
    assign job_midstate  = mid_q;
    assign mid_block_o   = gen_mid_block;
    // block2 stays zero until the first work unit so reset values hold
    assign job_block2    = loaded_q ? set_word(gen_block2, NONCE_WORD_IDX, nonce_q) : '0;
endmodule
